multiplicador_algoritmico: RTL and testbench
============================================

# multiplicador_algoritmico

Sequential signed multiply-accumulate that reconstructs a dividend from a divider result: Num = Coc·Den + Res. It is the inverse companion of the algorithmic divider and uses the same Start/Done level handshake and operand naming. A checker or datapath can chain the two blocks back-to-back for self-verification. The multiply is shift-add, one multiplier bit per clock.

## Interface
- tamanyo, 32: operand and result width in bits (two's complement), ≥ 4.
- CLK  in  1  system clock; all state updates on rising edge.
- RSTa  in  1  asynchronous reset, active-low.
- Start  in  1  level request, sampled only in IDLE.
- Coc  in  tamanyo  signed multiplicand (quotient).
- Den  in  tamanyo  signed multiplier (divisor).
- Res  in  tamanyo  signed addend (remainder).
- Num  out  tamanyo  signed result, low tamanyo bits of Coc·Den + Res; registered.
- Ovf  out  1  exact result is not representable in tamanyo signed bits; registered.
- Done  out  1  result valid; high only in state FIN.

## Operation
- Reset (RSTa = 0, any time, including mid-operation): state IDLE, Num = 0, Ovf = 0, Done = 0, internal accumulator, operands and counter cleared. Operation in progress is discarded.
- States: IDLE, OP, AJUSTE, FIN.
- IDLE: on an edge with Start = 1, latch Coc, Den and Res. Latch |Coc| and |Den| as tamanyo-bit unsigned magnitudes; the magnitude of the most negative value is 2^(tamanyo-1). Latch the sign as Coc[msb] XOR Den[msb]. Clear the 2·tamanyo-bit accumulator. Load the counter with tamanyo-1. Go to OP. Num and Ovf keep their previous values.
- OP: each edge examines the LSB of the multiplier magnitude. If it is 1, add the multiplicand magnitude, shifted by the current bit position, to the accumulator. Shift the multiplier right and decrement the counter. On the edge where the counter = 0, go to AJUSTE. Exactly tamanyo OP edges occur.
- AJUSTE: form the exact product P = sign ? −acc : acc at 2·tamanyo+1 bits. Compute S = P + sign-extended Res. Register Num = S[tamanyo-1:0]. Register Ovf = 1 if S < −2^(tamanyo-1) or S > 2^(tamanyo-1)−1. Go to FIN.
- FIN: Done = 1; Num and Ovf are held. Stay in FIN while Start = 1. On the first edge with Start = 0, go to IDLE. Done drops and Num/Ovf stay held until the next AJUSTE.
- Operand inputs are ignored outside the IDLE capture edge. Changes during OP, AJUSTE or FIN have no effect.
- Den = 0 or Coc = 0: the product is 0, Num = Res, Ovf = 0. There is no special path; the normal sequence applies.
- Start is ignored in OP and AJUSTE.

## Timing
- Capture edge = edge 0. OP occupies edges 1..tamanyo. AJUSTE executes on edge tamanyo+1. Done is high after edge tamanyo+1 (tamanyo+2 edges including capture; 34 for tamanyo = 32).
- Num and Ovf change only on the AJUSTE edge. They are stable whenever Done = 1.
- Done falls on the first edge after Start is seen low in FIN. A new capture requires at least one IDLE edge with Start = 1, so minimum spacing between captures is tamanyo+3 edges.
- If Start is still high through FIN, no restart occurs. This matches a driver that holds Start until it sees Done rise and then lowers it at the next falling edge.
- Asynchronous reset takes effect immediately. Outputs reach their reset values without waiting for a clock edge. Release is synchronous to the next edge; the first capture can occur on the first edge after RSTa rises.

## Test plan
- Sign cases, each driven at the falling edge with Start held until Done rises, checking Num with Ovf = 0:
  - (25,2,0) → 50
  - (2,3,1) → 7
  - (−5,−5,0) → 25
  - (−4,−4,1) → 17
  - (−5,10,0) → −50
  - (−5,8,−2) → −42
  - (2,−4,0) → −8
  - (1,−6,−3) → −9
- Zero operands: (0,0,0) → Num = 0. (0,7,5) → Num = 5. (123,0,−9) → Num = −9. Done appears exactly 34 edges after capture in every case.
- Overflow: (65536,65536,0) → Num = 0, Ovf = 1. (−2^31,1,−1) → Num = 2^31−1 bit pattern, Ovf = 1. (−2^31,−1,0) → Num = −2^31, Ovf = 1.
- Handshake:
  - Hold Start high for 10 cycles past Done → Done stays 1, Num unchanged, no second run.
  - Drop Start → Done = 0 one edge later.
  - Change Coc/Den during OP → result reflects the captured values only.
- Reset mid-operation: assert RSTa = 0 at OP edge 10 → Done = 0, Num = 0, Ovf = 0 immediately. After release, (7,3,1) → 22 with full latency.
- Back-to-back against the divider: random signed Num/Den (Den ≠ 0) through the divider, with its Coc/Res fed here → reconstructed Num equals the original, Ovf = 0.

Source files
------------

// File: rtl/multiplicador_algoritmico.sv
// Sequential signed multiply-accumulate: Num = Coc*Den + Res.
// Shift-add on operand magnitudes, one multiplier bit per clock, followed by
// a single sign-correction / accumulate step. Start/Done level handshake.
module multiplicador_algoritmico #(
   parameter int tamanyo = 32
) (
   input  logic               CLK,
   input  logic               RSTa,
   input  logic               Start,
   input  logic [tamanyo-1:0] Coc,
   input  logic [tamanyo-1:0] Den,
   input  logic [tamanyo-1:0] Res,
   output logic [tamanyo-1:0] Num,
   output logic               Ovf,
   output logic               Done
);

   localparam int W  = tamanyo;
   localparam int AW = 2 * W;
   localparam int PW = 2 * W + 1;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, OP, AJUSTE, FIN} state_t;

   state_t          state_reg;
   logic [AW-1:0]   mcand_reg;    // multiplicand magnitude, shifted left once per OP edge
   logic [W-1:0]    mplier_reg;   // multiplier magnitude, shifted right once per OP edge
   logic [W-1:0]    res_reg;
   logic            sign_reg;
   logic [AW-1:0]   acc_reg;
   logic [CW-1:0]   cnt_reg;
   logic [W-1:0]    num_reg;
   logic            ovf_reg;
   logic            done_reg;

   logic [W-1:0]    coc_mag;
   logic [W-1:0]    den_mag;
   logic [AW-1:0]   acc_next;
   logic [PW-1:0]   prod_ext;
   logic [PW-1:0]   sum_ext;
   logic [W+1:0]    sum_top;
   logic            ovf_next;

   // Magnitudes, partial-product accumulation and final signed sum with range check
   always_comb begin
      coc_mag  = Coc[W-1] ? (~Coc + W'(1)) : Coc;
      den_mag  = Den[W-1] ? (~Den + W'(1)) : Den;
      acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
      prod_ext = sign_reg ? (~{1'b0, acc_reg} + PW'(1)) : {1'b0, acc_reg};
      sum_ext  = prod_ext + {{(W+1){res_reg[W-1]}}, res_reg};
      // Representable only if every bit from the result MSB upward is a copy of the sign
      sum_top  = sum_ext[PW-1:W-1];
      ovf_next = !((&sum_top) || !(|sum_top));
   end

   // Control FSM and datapath registers
   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         state_reg  <= IDLE;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         res_reg    <= '0;
         sign_reg   <= 1'b0;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         num_reg    <= '0;
         ovf_reg    <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (Start) begin
                  mcand_reg  <= {{W{1'b0}}, coc_mag};
                  mplier_reg <= den_mag;
                  res_reg    <= Res;
                  sign_reg   <= Coc[W-1] ^ Den[W-1];
                  acc_reg    <= '0;
                  cnt_reg    <= CW'(W - 1);
                  state_reg  <= OP;
               end
            end
            OP: begin
               acc_reg    <= acc_next;
               mcand_reg  <= mcand_reg << 1;
               mplier_reg <= mplier_reg >> 1;
               if (cnt_reg == '0) begin
                  state_reg <= AJUSTE;
               end else begin
                  cnt_reg <= cnt_reg - CW'(1);
               end
            end
            AJUSTE: begin
               num_reg   <= sum_ext[W-1:0];
               ovf_reg   <= ovf_next;
               done_reg  <= 1'b1;
               state_reg <= FIN;
            end
            FIN: begin
               // Result is held until the requester withdraws Start
               if (!Start) begin
                  done_reg  <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: begin
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign Num  = num_reg;
   assign Ovf  = ovf_reg;
   assign Done = done_reg;

endmodule

// File: tb/tb_multiplicador_algoritmico.sv
module tb_multiplicador_algoritmico;

   logic        CLK;
   logic        RSTa;
   logic        Start;
   logic [31:0] Coc;
   logic [31:0] Den;
   logic [31:0] Res;
   logic [31:0] Num;
   logic        Ovf;
   logic        Done;

   int checks;
   int failures;

   multiplicador_algoritmico #(.tamanyo(32)) dut (
      .CLK   (CLK),
      .RSTa  (RSTa),
      .Start (Start),
      .Coc   (Coc),
      .Den   (Den),
      .Res   (Res),
      .Num   (Num),
      .Ovf   (Ovf),
      .Done  (Done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Starts an operation at a falling edge, holds Start until Done is seen,
   // returns the number of rising edges from capture to Done (inclusive), -1 on timeout.
   // scramble: change operands right after the capture edge.
   // drop: lower Start on Done and wait one more edge.
   task automatic run_op(input logic [31:0] c, input logic [31:0] d, input logic [31:0] r,
                         input bit scramble, input bit drop, output int lat);
      bit seen;
      @(negedge CLK);
      Coc = c; Den = d; Res = r; Start = 1'b1;
      lat = 0; seen = 0;
      while (!seen && lat < 100) begin
         @(posedge CLK);
         lat++;
         @(negedge CLK);
         if (scramble && lat == 1) begin
            Coc = $urandom; Den = $urandom; Res = $urandom;
         end
         if (Done) seen = 1;
      end
      if (!seen) lat = -1;
      if (drop) begin
         Start = 1'b0;
         @(negedge CLK);
      end
   endtask

   task automatic test_reset();
      RSTa = 1'b0; Start = 1'b0; Coc = '0; Den = '0; Res = '0;
      #2;
      checks++;
      if (Num !== 32'd0 || Ovf !== 1'b0 || Done !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: Num=%h Ovf=%b Done=%b expected 0/0/0", Num, Ovf, Done);
      end
      repeat (2) @(negedge CLK);
      RSTa = 1'b1;
      $display("test_reset: Num=%h Ovf=%b Done=%b", Num, Ovf, Done);
   endtask

   task automatic test_signs();
      logic [31:0] tc [8] = '{32'd25, 32'd2, -32'sd5, -32'sd4, -32'sd5, -32'sd5, 32'd2, 32'd1};
      logic [31:0] td [8] = '{32'd2, 32'd3, -32'sd5, -32'sd4, 32'd10, 32'd8, -32'sd4, -32'sd6};
      logic [31:0] tr [8] = '{32'd0, 32'd1, 32'd0, 32'd1, 32'd0, -32'sd2, 32'd0, -32'sd3};
      logic [31:0] te [8] = '{32'd50, 32'd7, 32'd25, 32'd17, -32'sd50, -32'sd42, -32'sd8, -32'sd9};
      int lat;
      for (int i = 0; i < 8; i++) begin
         run_op(tc[i], td[i], tr[i], 1'b0, 1'b0, lat);
         checks++;
         if (Num !== te[i] || Ovf !== 1'b0 || lat != 34) begin
            failures++;
            $display("FAIL sign_case%0d: Num=%0d Ovf=%b lat=%0d expected Num=%0d Ovf=0 lat=34",
                     i, $signed(Num), Ovf, lat, $signed(te[i]));
         end
         $display("test_signs: %0d*%0d+%0d -> Num=%0d Ovf=%b lat=%0d",
                  $signed(tc[i]), $signed(td[i]), $signed(tr[i]), $signed(Num), Ovf, lat);
         @(negedge CLK);
         Start = 1'b0;
         @(negedge CLK);
      end
   endtask

   task automatic test_zero();
      logic [31:0] tc [3] = '{32'd0, 32'd0, 32'd123};
      logic [31:0] td [3] = '{32'd0, 32'd7, 32'd0};
      logic [31:0] tr [3] = '{32'd0, 32'd5, -32'sd9};
      logic [31:0] te [3] = '{32'd0, 32'd5, -32'sd9};
      int lat;
      for (int i = 0; i < 3; i++) begin
         run_op(tc[i], td[i], tr[i], 1'b0, 1'b1, lat);
         checks++;
         if (Num !== te[i] || Ovf !== 1'b0 || lat != 34) begin
            failures++;
            $display("FAIL zero_case%0d: Num=%0d Ovf=%b lat=%0d expected Num=%0d Ovf=0 lat=34",
                     i, $signed(Num), Ovf, lat, $signed(te[i]));
         end
         $display("test_zero: %0d*%0d+%0d -> Num=%0d lat=%0d",
                  $signed(tc[i]), $signed(td[i]), $signed(tr[i]), $signed(Num), lat);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] tc [3] = '{32'd65536, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] td [3] = '{32'd65536, 32'd1, 32'hFFFF_FFFF};
      logic [31:0] tr [3] = '{32'd0, 32'hFFFF_FFFF, 32'd0};
      logic [31:0] te [3] = '{32'd0, 32'h7FFF_FFFF, 32'h8000_0000};
      int lat;
      for (int i = 0; i < 3; i++) begin
         run_op(tc[i], td[i], tr[i], 1'b0, 1'b1, lat);
         checks++;
         if (Num !== te[i] || Ovf !== 1'b1 || lat != 34) begin
            failures++;
            $display("FAIL ovf_case%0d: Num=%h Ovf=%b lat=%0d expected Num=%h Ovf=1 lat=34",
                     i, Num, Ovf, lat, te[i]);
         end
         $display("test_overflow: case%0d Num=%h Ovf=%b", i, Num, Ovf);
      end
   endtask

   task automatic test_handshake();
      int lat;
      run_op(32'd11, 32'd13, 32'd4, 1'b0, 1'b0, lat);
      checks++;
      if (Num !== 32'd147 || lat != 34) begin
         failures++;
         $display("FAIL hs_result: Num=%0d lat=%0d expected 147 lat=34", $signed(Num), lat);
      end
      for (int i = 0; i < 10; i++) begin
         Coc = 32'd3; Den = 32'd3; Res = 32'd3;
         @(negedge CLK);
         checks++;
         if (Done !== 1'b1 || Num !== 32'd147) begin
            failures++;
            $display("FAIL hs_hold%0d: Done=%b Num=%0d expected Done=1 Num=147", i, Done, $signed(Num));
         end
      end
      Start = 1'b0;
      @(negedge CLK);
      checks++;
      if (Done !== 1'b0 || Num !== 32'd147) begin
         failures++;
         $display("FAIL hs_drop: Done=%b Num=%0d expected Done=0 Num=147", Done, $signed(Num));
      end
      $display("test_handshake: held 10 cycles, after drop Done=%b Num=%0d", Done, $signed(Num));
   endtask

   task automatic test_operand_change();
      int lat;
      run_op(-32'sd9, 32'd12, 32'd5, 1'b1, 1'b1, lat);
      checks++;
      if (Num !== -32'sd103 || Ovf !== 1'b0 || lat != 34) begin
         failures++;
         $display("FAIL operand_change: Num=%0d Ovf=%b lat=%0d expected -103 Ovf=0 lat=34",
                  $signed(Num), Ovf, lat);
      end
      $display("test_operand_change: Num=%0d", $signed(Num));
   endtask

   task automatic test_reset_mid_op();
      int lat;
      @(negedge CLK);
      Coc = 32'd1000; Den = 32'd1000; Res = 32'd0; Start = 1'b1;
      repeat (11) @(posedge CLK);   // capture edge + OP edges 1..10
      #1;
      RSTa = 1'b0;
      Start = 1'b0;
      #1;
      checks++;
      if (Done !== 1'b0 || Num !== 32'd0 || Ovf !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_op: Done=%b Num=%h Ovf=%b expected 0/0/0", Done, Num, Ovf);
      end
      @(negedge CLK);
      RSTa = 1'b1;
      run_op(32'd7, 32'd3, 32'd1, 1'b0, 1'b1, lat);
      checks++;
      if (Num !== 32'd22 || Ovf !== 1'b0 || lat != 34) begin
         failures++;
         $display("FAIL after_reset: Num=%0d Ovf=%b lat=%0d expected 22 Ovf=0 lat=34",
                  $signed(Num), Ovf, lat);
      end
      $display("test_reset_mid_op: after release Num=%0d lat=%0d", $signed(Num), lat);
   endtask

   // Quotient/remainder pairs as a truncating divider would produce them
   task automatic test_back_to_back();
      logic [31:0] tn [6] = '{32'd100, -32'sd100, 32'd100, -32'sd100, 32'h7FFF_FFFF, 32'h8000_0000};
      logic [31:0] tq [6] = '{32'd14, -32'sd14, -32'sd14, 32'd14, 32'd715827882, -32'sd306783378};
      logic [31:0] td [6] = '{32'd7, 32'd7, -32'sd7, -32'sd7, 32'd3, 32'd7};
      logic [31:0] tr [6] = '{32'd2, -32'sd2, 32'd2, -32'sd2, 32'd1, -32'sd2};
      int lat;
      for (int i = 0; i < 6; i++) begin
         run_op(tq[i], td[i], tr[i], 1'b0, 1'b1, lat);
         checks++;
         if (Num !== tn[i] || Ovf !== 1'b0 || lat != 34) begin
            failures++;
            $display("FAIL b2b_case%0d: Num=%0d Ovf=%b lat=%0d expected %0d Ovf=0 lat=34",
                     i, $signed(Num), Ovf, lat, $signed(tn[i]));
         end
         $display("test_back_to_back: %0d*%0d+%0d -> Num=%0d",
                  $signed(tq[i]), $signed(td[i]), $signed(tr[i]), $signed(Num));
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_signs();
      test_zero();
      test_overflow();
      test_handshake();
      test_operand_change();
      test_reset_mid_op();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
